axis_rr_arbiter: RTL and testbench

- Packet-granular round-robin arbiter sharing one AXI4-Stream output between N AXI4-Stream requesters.
- Sits in front of the stream framing/marker block and feeds it whole packets from one source at a time.
- Once granted, a source holds the output until its s_tlast beat completes. The output is tagged with the source index.

---
 rtl/axis_rr_arbiter_if.sv | 28 ++
 rtl/axis_rr_arbiter.sv | 156 +++++++++++++++
 tb/tb_axis_rr_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_rr_arbiter_if.sv
// Bundle of N AXI4-Stream requesters plus one shared AXI4-Stream output.
// slave : arbiter view (consumes s_* streams, produces m_* stream)
// master: environment view (produces s_* streams, consumes m_* stream)
interface axis_rr_arbiter_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N      = 4,
  parameter int unsigned ID_W   = $clog2(N)
);
  logic [N*DATA_W-1:0] s_tdata;
  logic [N-1:0]        s_tvalid;
  logic [N-1:0]        s_tlast;
  logic [N-1:0]        s_tready;
  logic [DATA_W-1:0]   m_tdata;
  logic                m_tvalid;
  logic                m_tlast;
  logic [ID_W-1:0]     m_tid;
  logic                m_tready;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast, m_tid
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast, m_tid
  );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter: N AXI4-Stream sources share one output.
// A granted source owns the output until its tlast beat transfers; m_tid tags
// the owner. Optional macro AXIS_RR_ARB_OUT_REG_EN inserts a 2-entry skid
// buffer on the output (registered m_*, +1 cycle latency, full throughput).
module axis_rr_arbiter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N      = 4
) (
  input  logic                clk,
  input  logic                reset,
  axis_rr_arbiter_if.slave    bus,
  output logic                busy
);
  localparam int unsigned ID_W = $clog2(N);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            state;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   next_sel;
  logic [ID_W-1:0]   cand;
  logic              any_req;
  logic [DATA_W-1:0] g_data;
  logic              g_valid;
  logic              g_last;
  logic              accept;

  assign busy = (state == BUSY);

  // Round-robin search starting just after the previous winner, with wrap
  always_comb begin
    next_sel = '0;
    any_req  = 1'b0;
    cand     = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = ID_W'((32'(last_grant) + k) % N);
      if (!any_req && bus.s_tvalid[cand]) begin
        any_req  = 1'b1;
        next_sel = cand;
      end
    end
  end

  // Granted-source mux, selected by the registered grant
  always_comb begin
    g_data  = bus.s_tdata[32'(grant)*DATA_W +: DATA_W];
    g_valid = bus.s_tvalid[grant];
    g_last  = bus.s_tlast[grant];
  end

  // Arbitration FSM: IDLE picks a winner, BUSY holds it through tlast
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= ID_W'(N - 1);
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant      <= next_sel;
            last_grant <= next_sel;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (accept && g_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXIS_RR_ARB_OUT_REG_EN
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic [ID_W-1:0]   id;
  } beat_t;

  beat_t      skid [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       full;
  logic       pop;

  assign full   = (count == 2'd2);
  assign accept = (state == BUSY) && g_valid && !full;
  assign pop    = (count != 2'd0) && bus.m_tready;

  // Two-entry skid FIFO decoupling source ready from downstream ready
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid[0] <= '0;
      skid[1] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
    end else begin
      if (accept) begin
        skid[wr_ptr] <= '{data: g_data, last: g_last, id: grant};
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Output from buffer head; granted source sees the buffer's space
  always_comb begin
    bus.s_tready = '0;
    bus.m_tdata  = '0;
    bus.m_tvalid = 1'b0;
    bus.m_tlast  = 1'b0;
    bus.m_tid    = '0;
    if (state == BUSY) begin
      bus.s_tready[grant] = !full;
    end
    if (count != 2'd0) begin
      bus.m_tdata  = skid[rd_ptr].data;
      bus.m_tvalid = 1'b1;
      bus.m_tlast  = skid[rd_ptr].last;
      bus.m_tid    = skid[rd_ptr].id;
    end
  end
`else
  assign accept = (state == BUSY) && g_valid && bus.m_tready;

  // Pure combinational pass-through of the granted source
  always_comb begin
    bus.s_tready = '0;
    bus.m_tdata  = '0;
    bus.m_tvalid = 1'b0;
    bus.m_tlast  = 1'b0;
    bus.m_tid    = '0;
    if (state == BUSY) begin
      bus.s_tready[grant] = bus.m_tready;
      bus.m_tdata         = g_data;
      bus.m_tvalid        = g_valid;
      bus.m_tlast         = g_last;
      bus.m_tid           = grant;
    end
  end
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: per-source beat queues feed the DUT, expected
// output beats go into a scoreboard that is popped on every output transfer.
module tb_axis_rr_arbiter;
  localparam int unsigned N      = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ID_W   = 2;

  logic clk = 1'b0;
  logic reset;
  logic busy;

  axis_rr_arbiter_if #(.DATA_W(DATA_W), .N(N)) bus ();

  axis_rr_arbiter #(.DATA_W(DATA_W), .N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } src_beat_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic [ID_W-1:0]   id;
  } exp_t;

  typedef struct {
    logic [N-1:0] mask;
    int           n;
    int           order [4];
  } vec_t;

  src_beat_t    srcq [N][$];
  exp_t         sb [$];
  vec_t         tbl [6];
  logic [N-1:0] hs;
  logic         prev_last_fire;
  logic         rst_req;
  logic         mready_req;
  int           checks = 0;
  int           errors = 0;
  int           n_fire = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic load(input int s, input logic [DATA_W-1:0] d, input logic l);
    srcq[s].push_back('{data: d, last: l});
  endtask

  task automatic expect_beat(input logic [DATA_W-1:0] d, input logic l, input int id);
    sb.push_back('{data: d, last: l, id: ID_W'(id)});
  endtask

  // Apply handshakes seen last cycle, then present each source's next beat
  task automatic drive();
    for (int i = 0; i < int'(N); i++) begin
      if (hs[i] && srcq[i].size() > 0) srcq[i].delete(0);
      if (srcq[i].size() > 0) begin
        bus.s_tvalid[i]                  = 1'b1;
        bus.s_tdata[i*DATA_W +: DATA_W] = srcq[i][0].data;
        bus.s_tlast[i]                   = srcq[i][0].last;
      end else begin
        bus.s_tvalid[i]                  = 1'b0;
        bus.s_tdata[i*DATA_W +: DATA_W] = '0;
        bus.s_tlast[i]                   = 1'b0;
      end
    end
    hs           = '0;
    reset        = rst_req;
    bus.m_tready = mready_req;
  endtask

  // Sample outputs mid-cycle; transfers happen on the following rising edge
  task automatic monitor();
    logic fire;
    exp_t e;
    fire = bus.m_tvalid && bus.m_tready;
    if (prev_last_fire) check("bubble_after_tlast", 32'({busy, bus.m_tvalid}), 32'd0);
    if (bus.m_tvalid) check("busy_while_valid", 32'(busy), 32'd1);
    if (busy) check("s_tready_only_granted", 32'(bus.s_tready & ~(N'(1) << bus.m_tid)), 32'd0);
    else      check("s_tready_idle", 32'(bus.s_tready), 32'd0);
    if (fire) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data 0x%0h tid %0d, expected no beat at t=%0t",
                 bus.m_tdata, bus.m_tid, $time);
      end else begin
        e = sb.pop_front();
        check("beat{data,last,tid}", 32'({bus.m_tdata, bus.m_tlast, bus.m_tid}), 32'(e));
      end
      n_fire++;
    end
    hs             = bus.s_tvalid & bus.s_tready;
    prev_last_fire = fire && bus.m_tlast;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    monitor();
  endtask

  task automatic drain(input int budget, output int cycles);
    cycles = 0;
    while (sb.size() > 0 && cycles < budget) begin
      tick();
      cycles++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    tick();
    tick();
  endtask

  task automatic wait_fires(input int target, input int budget);
    int c;
    c = 0;
    while (n_fire < target && c < budget) begin
      tick();
      c++;
    end
    check("wait_fires_timeout", 32'(n_fire >= target), 32'd1);
  endtask

  task automatic set_vec(input int v, input logic [N-1:0] m, input int n,
                         input int o0, input int o1, input int o2, input int o3);
    tbl[v].mask     = m;
    tbl[v].n        = n;
    tbl[v].order[0] = o0;
    tbl[v].order[1] = o1;
    tbl[v].order[2] = o2;
    tbl[v].order[3] = o3;
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({bus.m_tvalid, bus.m_tlast, bus.m_tid, bus.m_tdata, busy, bus.s_tready});
  endfunction

  initial begin
    int cyc;
    int base;
    logic [DATA_W-1:0] d;

    // Request masks and the grant order they must produce, pointer carried over
    set_vec(0, 4'b0101, 2, 0, 2, 0, 0);
    set_vec(1, 4'b1111, 4, 3, 0, 1, 2);
    set_vec(2, 4'b0010, 1, 1, 0, 0, 0);
    set_vec(3, 4'b0011, 2, 0, 1, 0, 0);
    set_vec(4, 4'b1001, 2, 3, 0, 0, 0);
    set_vec(5, 4'b0110, 2, 1, 2, 0, 0);

    hs             = '0;
    prev_last_fire = 1'b0;
    rst_req        = 1'b0;
    mready_req     = 1'b1;
    drive();

    // Reset with every source requesting, then first grant goes to source 0
    for (int i = 0; i < int'(N); i++) begin
      load(i, 8'(8'hA0 + i), 1'b1);
      expect_beat(8'(8'hA0 + i), 1'b1, i);
    end
    for (int r = 0; r < 3; r++) begin
      tick();
      check("reset_outputs_zero", all_outputs(), 32'd0);
    end
    rst_req = 1'b1;
    tick();
    check("arb_cycle_idle", 32'({busy, bus.m_tvalid}), 32'd0);
    tick();
    check("first_grant_tid0", 32'({bus.m_tvalid, bus.m_tid}), 32'({1'b1, 2'd0}));
    drain(40, cyc);

    // Round-robin: two 2-beat packets per source, one bubble per packet
    for (int p = 0; p < 2; p++) begin
      for (int s = 0; s < int'(N); s++) begin
        for (int b = 0; b < 2; b++) begin
          d = 8'(p*64 + s*16 + b + 1);
          load(s, d, b == 1);
          expect_beat(d, b == 1, s);
        end
      end
    end
    drain(100, cyc);
    check("rr_total_cycles", 32'(cyc), 32'd24);

    // Table of simultaneous single-beat requests against the rotating pointer
    for (int v = 0; v < 6; v++) begin
      for (int s = 0; s < int'(N); s++) begin
        if (tbl[v].mask[s]) load(s, 8'(8'h80 + v*16 + s), 1'b1);
      end
      for (int k = 0; k < tbl[v].n; k++) begin
        expect_beat(8'(8'h80 + v*16 + tbl[v].order[k]), 1'b1, tbl[v].order[k]);
      end
      drain(60, cyc);
    end

    // Single source, three beats
    load(2, 8'h11, 1'b0); expect_beat(8'h11, 1'b0, 2);
    load(2, 8'h22, 1'b0); expect_beat(8'h22, 1'b0, 2);
    load(2, 8'h33, 1'b1); expect_beat(8'h33, 1'b1, 2);
    drain(40, cyc);

    // Backpressure for three cycles in the middle of a source-1 packet
    base = n_fire;
    for (int b = 0; b < 4; b++) begin
      load(1, 8'(8'hB1 + b), b == 3);
      expect_beat(8'(8'hB1 + b), b == 3, 1);
    end
    wait_fires(base + 2, 20);
    mready_req = 1'b0;
    for (int r = 0; r < 3; r++) begin
      tick();
      check("bp_data_held", 32'({bus.m_tvalid, bus.m_tdata}), 32'({1'b1, 8'hB3}));
      check("bp_s_tready1_low", 32'(bus.s_tready[1]), 32'd0);
    end
    mready_req = 1'b1;
    drain(40, cyc);

    // Reset in the middle of a 5-beat packet from source 3
    base = n_fire;
    for (int b = 0; b < 5; b++) begin
      load(3, 8'(8'hC1 + b), b == 4);
      expect_beat(8'(8'hC1 + b), b == 4, 3);
    end
    wait_fires(base + 2, 20);
    @(posedge clk);
    #1;
    drive();
    #2;
    rst_req = 1'b0;
    reset   = 1'b0;
    #1;
    check("midpkt_reset_outputs_zero", all_outputs(), 32'd0);
    srcq[3].delete();
    sb.delete();
    prev_last_fire = 1'b0;
    tick();
    tick();
    load(3, 8'hD1, 1'b0); expect_beat(8'hD1, 1'b0, 3);
    load(3, 8'hD2, 1'b1); expect_beat(8'hD2, 1'b1, 3);
    rst_req = 1'b1;
    tick();
    check("post_reset_arb_idle", 32'({busy, bus.m_tvalid}), 32'd0);
    tick();
    check("post_reset_regrant_tid3", 32'({bus.m_tvalid, bus.m_tid}), 32'({1'b1, 2'd3}));
    drain(40, cyc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
